// File: rtl/mult_booth_unit.sv
// rtl/mult_booth_unit.sv - sequential radix-2 Booth multiplier for the MULT instruction
//
// Optional feature macro: MULT_BOOTH_MULTU_EN (adds the multu port for unsigned products)
//
// Ports:
//   clk          rising-edge clock
//   reset_in     asynchronous active-low reset
//   mult_control start request, sampled only in IDLE
//   multu        (MULT_BOOTH_MULTU_EN only) 1 = unsigned product, sampled with mult_control
//   a_in         multiplicand (A register)
//   b_in         multiplier (B register)
//   hi_out       product[2*WIDTH-1:WIDTH] to the HI register
//   lo_out       product[WIDTH-1:0] to the LO register
//   mult_end     one-cycle completion pulse
//   busy         high while running and during the completion cycle

module mult_booth_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             mult_control,
`ifdef MULT_BOOTH_MULTU_EN
    input  logic             multu,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             mult_end,
    output logic             busy
);

    // Internal operand width: one extra bit when unsigned operands must be
    // zero-extended so that Booth recoding treats them as positive.
`ifdef MULT_BOOTH_MULTU_EN
    localparam int XW = WIDTH + 1;
`else
    localparam int XW = WIDTH;
`endif
    // Product register: {accumulator (XW), multiplier (XW), booth history bit}
    localparam int PW = 2 * XW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [XW-1:0]      m_q;
    logic [PW-1:0]      p_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               busy_q;
`ifdef MULT_BOOTH_MULTU_EN
    logic               unsigned_q;
`endif

    logic [XW:0]        acc_ext;
    logic [XW:0]        m_ext;
    logic [XW:0]        sum_d;
    logic [PW-1:0]      p_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [CNT_W-1:0]   last_cnt;
    logic [XW-1:0]      m_load;
    logic [XW-1:0]      b_load;

    // Operand conditioning at the start edge.
    always_comb begin
`ifdef MULT_BOOTH_MULTU_EN
        m_load = multu ? {1'b0, a_in} : {a_in[WIDTH-1], a_in};
        b_load = multu ? {1'b0, b_in} : {b_in[WIDTH-1], b_in};
`else
        m_load = a_in;
        b_load = b_in;
`endif
    end

    // One Booth step. The add/subtract runs one bit wider than the
    // accumulator so that the most negative multiplicand cannot overflow;
    // the shift then keeps that extra bit as the new sign.
    always_comb begin
        acc_ext = {p_q[PW-1], p_q[PW-1:XW+1]};
        m_ext   = {m_q[XW-1], m_q};
        sum_d   = acc_ext;
        case (p_q[1:0])
            2'b01:   sum_d = acc_ext + m_ext;
            2'b10:   sum_d = acc_ext - m_ext;
            default: sum_d = acc_ext;
        endcase
        p_d = {sum_d, p_q[XW:1]};
    end

    // Result extraction and iteration count. A signed operation runs only
    // WIDTH steps on the widened register, so its product sits one bit
    // higher than after the full XW steps of an unsigned operation.
    always_comb begin
`ifdef MULT_BOOTH_MULTU_EN
        if (unsigned_q) begin
            prod_d   = p_d[2*WIDTH:1];
            last_cnt = CNT_W'(XW - 1);
        end else begin
            prod_d   = p_d[2*WIDTH+1:2];
            last_cnt = CNT_W'(WIDTH - 1);
        end
`else
        prod_d   = p_d[2*WIDTH:1];
        last_cnt = CNT_W'(WIDTH - 1);
`endif
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            m_q        <= '0;
            p_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef MULT_BOOTH_MULTU_EN
            unsigned_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (mult_control) begin
                        m_q     <= m_load;
                        p_q     <= {{XW{1'b0}}, b_load, 1'b0};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef MULT_BOOTH_MULTU_EN
                        unsigned_q <= multu;
`endif
                    end
                end
                RUN: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == last_cnt) begin
                        hi_q    <= prod_d[2*WIDTH-1:WIDTH];
                        lo_q    <= prod_d[WIDTH-1:0];
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign mult_end = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mult_booth_unit.sv
// tb/tb_mult_booth_unit.sv - directed self-checking bench for mult_booth_unit

module tb_mult_booth_unit;

    logic        clk;
    logic        reset_in;
    logic        mult_control;
`ifdef MULT_BOOTH_MULTU_EN
    logic        multu;
`endif
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        mult_end;
    logic        busy;

    int pass_cnt;
    int total_cnt;

    mult_booth_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .reset_in     (reset_in),
        .mult_control (mult_control),
`ifdef MULT_BOOTH_MULTU_EN
        .multu        (multu),
`endif
        .a_in         (a_in),
        .b_in         (b_in),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .mult_end     (mult_end),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts one operation, scrambles the operand inputs after the start
    // edge, and waits (bounded) for mult_end. lat = clock edges after the
    // start edge at which mult_end is first seen (80 on timeout);
    // bc = sampled cycles with busy high up to and including that one.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic u,
                          output int lat, output int bc);
        @(negedge clk);
        a_in = a;
        b_in = b;
        mult_control = 1'b1;
`ifdef MULT_BOOTH_MULTU_EN
        multu = u;
`else
        if (u) a_in = a;
`endif
        @(posedge clk);
        @(negedge clk);
        mult_control = 1'b0;
        a_in = ~a;
        b_in = ~b;
        lat = 0;
        bc  = 0;
        while (lat < 80) begin
            if (busy) bc++;
            if (mult_end) break;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b0;
        mult_control = 1'b0;
        a_in = 32'h0;
        b_in = 32'h0;
`ifdef MULT_BOOTH_MULTU_EN
        multu = 1'b0;
`endif
        repeat (3) @(negedge clk);
        total_cnt++;
        if (hi_out !== 32'h0) $display("FAIL reset_hi: got %h expected 00000000", hi_out);
        else pass_cnt++;
        total_cnt++;
        if (lo_out !== 32'h0) $display("FAIL reset_lo: got %h expected 00000000", lo_out);
        else pass_cnt++;
        total_cnt++;
        if (mult_end !== 1'b0) $display("FAIL reset_mult_end: got %b expected 0", mult_end);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else pass_cnt++;
        reset_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_signed_positive();
        int lat, bc;
        run_op(32'd7, 32'd3, 1'b0, lat, bc);
        total_cnt++;
        if (lat !== 32) $display("FAIL pos_latency: got %0d expected 32 edges after start", lat);
        else pass_cnt++;
        total_cnt++;
        if (bc !== 33) $display("FAIL pos_busy_cycles: got %0d expected 33", bc);
        else pass_cnt++;
        total_cnt++;
        if (hi_out !== 32'h0) $display("FAIL pos_hi: got %h expected 00000000", hi_out);
        else pass_cnt++;
        total_cnt++;
        if (lo_out !== 32'h15) $display("FAIL pos_lo: got %h expected 00000015", lo_out);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (mult_end !== 1'b0) $display("FAIL pos_end_pulse: got %b expected 0", mult_end);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL pos_busy_after: got %b expected 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (lo_out !== 32'h15) $display("FAIL pos_lo_hold: got %h expected 00000015", lo_out);
        else pass_cnt++;
    endtask

    task automatic test_mixed_sign();
        int lat, bc;
        run_op(32'hFFFF_FFFF, 32'h1, 1'b0, lat, bc);
        total_cnt++;
        if (lat !== 32) $display("FAIL mixed_latency: got %0d expected 32", lat);
        else pass_cnt++;
        total_cnt++;
        if (hi_out !== 32'hFFFF_FFFF) $display("FAIL mixed_hi: got %h expected ffffffff", hi_out);
        else pass_cnt++;
        total_cnt++;
        if (lo_out !== 32'hFFFF_FFFF) $display("FAIL mixed_lo: got %h expected ffffffff", lo_out);
        else pass_cnt++;
    endtask

    task automatic test_extreme();
        int lat, bc;
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, lat, bc);
        total_cnt++;
        if (hi_out !== 32'h4000_0000) $display("FAIL extreme_hi: got %h expected 40000000", hi_out);
        else pass_cnt++;
        total_cnt++;
        if (lo_out !== 32'h0) $display("FAIL extreme_lo: got %h expected 00000000", lo_out);
        else pass_cnt++;
        // -3 * -7 = 21
        run_op(32'hFFFF_FFFD, 32'hFFFF_FFF9, 1'b0, lat, bc);
        total_cnt++;
        if ({hi_out, lo_out} !== 64'h15) $display("FAIL negneg_prod: got %h expected 0000000000000015", {hi_out, lo_out});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, lat, bc);
        total_cnt++;
        if ({hi_out, lo_out} !== 64'hFFFF_FFFF_0000_0002)
            $display("FAIL b2b_first: got %h expected ffffffff00000002", {hi_out, lo_out});
        else pass_cnt++;
        // Next start issued in the first IDLE cycle after DONE.
        run_op(32'h0001_0000, 32'h0001_0000, 1'b0, lat, bc);
        total_cnt++;
        if (lat !== 32) $display("FAIL b2b_latency: got %0d expected 32", lat);
        else pass_cnt++;
        total_cnt++;
        if ({hi_out, lo_out} !== 64'h1_0000_0000)
            $display("FAIL b2b_second: got %h expected 0000000100000000", {hi_out, lo_out});
        else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        int k, ends, first_end;
        @(negedge clk);
        a_in = 32'd5;
        b_in = 32'd6;
        mult_control = 1'b1;
`ifdef MULT_BOOTH_MULTU_EN
        multu = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        mult_control = 1'b0;
        ends = 0;
        first_end = -1;
        for (k = 0; k < 73; k++) begin
            if (k == 9) begin
                a_in = 32'd9;
                mult_control = 1'b1;
            end else begin
                mult_control = 1'b0;
            end
            if (k == 16) begin
                total_cnt++;
                if (hi_out !== 32'h1) $display("FAIL busy_hold_mid_run: got %h expected 00000001", hi_out);
                else pass_cnt++;
            end
            if (mult_end) begin
                ends++;
                if (first_end < 0) first_end = k;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (ends !== 1) $display("FAIL busy_end_count: got %0d expected 1", ends);
        else pass_cnt++;
        total_cnt++;
        if (first_end !== 32) $display("FAIL busy_end_time: got %0d expected 32", first_end);
        else pass_cnt++;
        total_cnt++;
        if (lo_out !== 32'h1E) $display("FAIL busy_lo: got %h expected 0000001e", lo_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int k, ends, lat, bc;
        @(negedge clk);
        a_in = 32'd100;
        b_in = 32'd100;
        mult_control = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mult_control = 1'b0;
        repeat (14) @(negedge clk);
        #2;
        reset_in = 1'b0;
        #1;
        total_cnt++;
        if (hi_out !== 32'h0) $display("FAIL rst_mid_hi: got %h expected 00000000", hi_out);
        else pass_cnt++;
        total_cnt++;
        if (lo_out !== 32'h0) $display("FAIL rst_mid_lo: got %h expected 00000000", lo_out);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        reset_in = 1'b1;
        ends = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mult_end) ends++;
        end
        total_cnt++;
        if (ends !== 0) $display("FAIL rst_mid_no_end: got %0d pulses expected 0", ends);
        else pass_cnt++;
        run_op(32'd2, 32'd2, 1'b0, lat, bc);
        total_cnt++;
        if (lat !== 32) $display("FAIL rst_after_latency: got %0d expected 32", lat);
        else pass_cnt++;
        total_cnt++;
        if (lo_out !== 32'h4) $display("FAIL rst_after_lo: got %h expected 00000004", lo_out);
        else pass_cnt++;
    endtask

`ifdef MULT_BOOTH_MULTU_EN
    task automatic test_multu();
        int lat, bc;
        run_op(32'hFFFF_FFFF, 32'h2, 1'b1, lat, bc);
        total_cnt++;
        if (lat !== 33) $display("FAIL multu_latency: got %0d expected 33", lat);
        else pass_cnt++;
        total_cnt++;
        if ({hi_out, lo_out} !== 64'h1_FFFF_FFFE)
            $display("FAIL multu_prod: got %h expected 00000001fffffffe", {hi_out, lo_out});
        else pass_cnt++;
        run_op(32'hFFFF_FFFF, 32'h2, 1'b0, lat, bc);
        total_cnt++;
        if (lat !== 32) $display("FAIL mult_s_latency: got %0d expected 32", lat);
        else pass_cnt++;
        total_cnt++;
        if ({hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_FFFE)
            $display("FAIL mult_s_prod: got %h expected fffffffffffffffe", {hi_out, lo_out});
        else pass_cnt++;
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, lat, bc);
        total_cnt++;
        if ({hi_out, lo_out} !== 64'h4000_0000_0000_0000)
            $display("FAIL multu_big: got %h expected 4000000000000000", {hi_out, lo_out});
        else pass_cnt++;
    endtask
`endif

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_signed_positive();
        test_mixed_sign();
        test_extreme();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
`ifdef MULT_BOOTH_MULTU_EN
        test_multu();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mult_booth_unit.md
Name: mult_booth_unit

Overview:
- Sequential signed 32x32 multiplier executing the R-type MULT instruction for the multicycle datapath.
- Started by the control unit's `mult_control` pulse.
- Reports completion on `mult_end` with the 64-bit product on `hi_out`/`lo_out`; the control unit then asserts `HI_reg_w`/`LO_reg_w`.
- Radix-2 Booth algorithm, one iteration per clock. Operands come from the A and B registers.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- mult_control  input  1  start request, sampled only in IDLE.
- a_in  input  WIDTH  multiplicand (A register).
- b_in  input  WIDTH  multiplier (B register).
- hi_out  output  WIDTH  product[2*WIDTH-1:WIDTH], to HI register.
- lo_out  output  WIDTH  product[WIDTH-1:0], to LO register.
- mult_end  output  1  one-cycle done pulse.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Reset: reset_in low clears outputs immediately, regardless of clk.
  - State = IDLE; counter = 0; internal product/multiplicand registers = 0.
  - hi_out = 0, lo_out = 0, mult_end = 0, busy = 0.
- Reset mid-operation: aborts the computation. No mult_end is produced. hi_out/lo_out read 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If mult_control = 1 at edge T0: latch multiplicand M = a_in.
  - Load product register P[2*WIDTH:0] = {WIDTH zeros, b_in, 1'b0}.
  - counter = 0; go to RUN; busy = 1.
  - Otherwise stay in IDLE; hi_out/lo_out hold the last result.
- RUN, each edge, examine P[1:0]:
  - 01: upper WIDTH bits of P += M.
  - 10: upper WIDTH bits of P -= M.
  - 00/11: no change.
  - Add/subtract in WIDTH+1 bits; result then arithmetic-shifted right by 1 over the full 2*WIDTH+1 bits, preserving the sign of the sum.
  - counter += 1. After WIDTH iterations (edge T0+WIDTH) go to DONE.
  - Each edge in RUN ignores mult_control and does not restart.
- DONE (entered at edge T0+WIDTH):
  - {hi_out, lo_out} = P[2*WIDTH:1].
  - mult_end = 1 for exactly this one cycle; busy = 1.
  - Next edge: mult_end = 0, busy = 0, state = IDLE. hi_out/lo_out held until the next completion or reset.
- Latency: mult_end high during the cycle following edge T0+WIDTH, i.e. WIDTH+1 clocks after the start edge (33 for WIDTH = 32).
- Outputs: hi_out/lo_out are registered and change only on entry to DONE, never mid-RUN.
- mult_control in DONE is ignored. A new start is accepted only from IDLE, at earliest the edge after DONE.
- Operand capture: a_in/b_in are sampled only at the start edge; later changes have no effect.
- Arithmetic: two's complement.
  - Full range is correct, including a_in = 0x80000000; the WIDTH+1-bit accumulator prevents overflow.
  - No overflow flag; the 64-bit product is always exact.

Optional Feature:
- Macro: MULT_BOOTH_MULTU_EN.
- When defined:
  - Extra input port `multu` (1 bit), sampled with mult_control.
  - When multu = 1, operands are zero-extended to WIDTH+1 bits and WIDTH+1 Booth iterations run.
  - {hi_out, lo_out} is the unsigned product; latency is WIDTH+2 clocks.
  - multu = 0 behaves exactly as the signed path.
- When undefined: no multu port; signed only; latency WIDTH+1.

Test Plan:
- Signed positive: a_in = 7, b_in = 3, one-cycle mult_control → mult_end exactly 33 cycles after the start edge; hi_out = 0x00000000, lo_out = 0x00000015; busy high for 33 cycles.
- Mixed sign: a_in = 0xFFFFFFFF (-1), b_in = 0x00000001 → hi_out = 0xFFFFFFFF, lo_out = 0xFFFFFFFF.
- Extreme operands: a_in = b_in = 0x80000000 → hi_out = 0x40000000, lo_out = 0x00000000.
- Busy handling:
  - Start with a_in = 5, b_in = 6.
  - Pulse mult_control again at cycle 10 with a_in = 9.
  - Required: single mult_end at cycle 33, lo_out = 0x0000001E; no second mult_end within the next 40 cycles.
- Reset mid-op: start 100*100, drive reset_in low at cycle 15 between edges → hi_out, lo_out, busy drop to 0 immediately; no mult_end. Release reset, start 2*2 → lo_out = 4 after 33 cycles.
- With MULT_BOOTH_MULTU_EN: multu = 1, a_in = 0xFFFFFFFF, b_in = 2 → hi_out = 0x00000001, lo_out = 0xFFFFFFFE after 34 cycles. Same operands with multu = 0 → hi_out = 0xFFFFFFFF, lo_out = 0xFFFFFFFE after 33 cycles.
